// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry (main + skid) pipeline register with stall/flush and bubble/stall counters.
// Counters are built only when PIPE_STAGE_PERF_EN is defined; otherwise they read as constant 0.
module pipe_stage_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_c, skid_c;
  logic [DATA_W-1:0] main_d, skid_d;
  logic              accept, send;
  // ready_o is purely the registered skid-empty bit, so ready_i never reaches it
  assign ready_o = ~skid_v;
  assign accept  = valid_i & ready_o;
  assign send    = main_v & ready_i & ~stall_i;
  assign valid_o = main_v;
  assign ctrl_o  = main_v ? main_c : '0;
  assign data_o  = main_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_c <= '0;
      skid_c <= '0;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_c <= '0;
      skid_c <= '0;
    end else if (send && skid_v) begin
      main_v <= 1'b1;
      main_c <= skid_c;
      main_d <= skid_d;
      skid_v <= 1'b0;
    end else if (accept && (!main_v || send)) begin
      main_v <= 1'b1;
      main_c <= ctrl_i;
      main_d <= data_i;
    end else if (accept) begin
      skid_v <= 1'b1;
      skid_c <= ctrl_i;
      skid_d <= data_i;
    end else if (send) begin
      main_v <= 1'b0;
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] bubble_cnt, stall_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (!main_v && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (main_v && !send && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
  assign bubble_cnt_o = bubble_cnt;
  assign stall_cnt_o  = stall_cnt;
`else
  assign bubble_cnt_o = '0;
  assign stall_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg against a two-slot FIFO model.
module tb_pipe_stage_reg;
  localparam int DW = 160;
  localparam int CW = 10;
  localparam int NW = 4;
  localparam int CMAX = (1 << NW) - 1;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct packed {logic [CW-1:0] c; logic [DW-1:0] d;} item_t;
  logic clk = 0, rst_n = 0, valid_i = 0, ready_i = 0, stall_i = 0, flush_i = 0;
  logic [CW-1:0] ctrl_i = '0;
  logic [DW-1:0] data_i = '0;
  logic ready_o, valid_o;
  logic [CW-1:0] ctrl_o;
  logic [DW-1:0] data_o;
  logic [NW-1:0] bubble_cnt_o, stall_cnt_o;
  int n_chk = 0, n_fail = 0;
  item_t mq[$];
  int mbub = 0, mstl = 0;
  bit armed = 0;
  logic [DW-1:0] out_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
    .ctrl_o(ctrl_o), .data_o(data_o), .stall_i(stall_i), .flush_i(flush_i),
    .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int sat(int n);
    return PERF ? (n > CMAX ? CMAX : n) : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the stage is an in-order FIFO of depth two; counters count observed cycles.
  always @(posedge clk) begin
    bit v, snd, acc;
    if (!rst_n) begin
      mq.delete();
      mbub = 0;
      mstl = 0;
      armed = 1;
    end else begin
      v = mq.size() != 0;
      snd = v && ready_i && !stall_i;
      acc = valid_i && mq.size() < 2;
      if (!v) mbub++;
      else if (!snd) mstl++;
      if (flush_i) mq.delete();
      else begin
        if (snd) void'(mq.pop_front());
        if (acc) mq.push_back(item_t'({ctrl_i, data_i}));
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("valid_o", valid_o, mq.size() != 0);
      chk("ready_o", ready_o, mq.size() < 2);
      if (mq.size() != 0) begin
        chk("ctrl_o", ctrl_o, mq[0].c);
        chk("data_o", data_o, mq[0].d);
      end else chk("ctrl_o_gated", ctrl_o, 0);
      chk("bubble_cnt_o", bubble_cnt_o, sat(mbub));
      chk("stall_cnt_o", stall_cnt_o, sat(mstl));
    end
    if (rst_n && !flush_i && valid_o && ready_i && !stall_i) out_q.push_back(data_o);
  end

  initial begin
    int idx;
    bit acc;
    tick();
    tick();
    chk("rst_valid_o", valid_o, 0);
    chk("rst_ready_o", ready_o, 1);
    chk("rst_ctrl_o", ctrl_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_bubble", bubble_cnt_o, 0);
    chk("rst_stall", stall_cnt_o, 0);
    rst_n = 1;
    // single transfer, one cycle latency
    valid_i = 1; ctrl_i = 10'h3FF; data_i = DW'('hA5); ready_i = 1;
    tick();
    valid_i = 0;
    chk("single_valid", valid_o, 1);
    chk("single_ctrl", ctrl_o, 10'h3FF);
    chk("single_data", data_o, 'hA5);
    tick();
    chk("single_drain_valid", valid_o, 0);
    chk("single_drain_ctrl", ctrl_o, 0);
    // three items with downstream backpressure on cycles 2-3
    out_q.delete();
    idx = 1;
    for (int c = 1; c <= 8; c++) begin
      valid_i = idx <= 3;
      data_i = DW'(idx);
      ctrl_i = CW'(idx);
      ready_i = !(c == 2 || c == 3);
      acc = valid_i && ready_o;
      tick();
      if (acc) idx++;
      if (c == 2) chk("skid_full_ready", ready_o, 0);
    end
    valid_i = 0;
    chk("order_count", out_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < out_q.size()) chk("order_item", out_q[i], i + 1);
    // flush with both entries full and a same-cycle input
    ready_i = 0; valid_i = 1; ctrl_i = 10'h0F0; data_i = DW'('h11);
    tick();
    data_i = DW'('h12);
    tick();
    chk("both_full_ready", ready_o, 0);
    out_q.delete();
    flush_i = 1; data_i = DW'('h99); ctrl_i = 10'h155;
    tick();
    flush_i = 0; valid_i = 0;
    chk("flush_valid", valid_o, 0);
    chk("flush_ctrl", ctrl_o, 0);
    chk("flush_ready", ready_o, 1);
    ready_i = 1;
    repeat (3) tick();
    chk("flush_no_leak", out_q.size(), 0);
    // stall and flush together
    ready_i = 0; valid_i = 1; data_i = DW'('h21); ctrl_i = 10'h021;
    tick();
    valid_i = 0; stall_i = 1; flush_i = 1;
    tick();
    stall_i = 0; flush_i = 0;
    chk("stall_flush_valid", valid_o, 0);
    // stall counter saturation
    rst_n = 0;
    tick();
    rst_n = 1; valid_i = 1; data_i = DW'('h31); ctrl_i = 10'h031; ready_i = 0;
    tick();
    valid_i = 0;
    repeat (20) tick();
    chk("stall_sat", stall_cnt_o, PERF ? 15 : 0);
    chk("bubble_one", bubble_cnt_o, PERF ? 1 : 0);
    repeat (3) tick();
    chk("stall_sat_held", stall_cnt_o, PERF ? 15 : 0);
    // reset while both entries are full
    valid_i = 1; data_i = DW'('h32); ctrl_i = 10'h032;
    tick();
    valid_i = 0;
    chk("pre_rst_full", ready_o, 0);
    out_q.delete();
    rst_n = 0; ready_i = 1;
    tick();
    rst_n = 1;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_ctrl", ctrl_o, 0);
    chk("mid_rst_bubble", bubble_cnt_o, 0);
    chk("mid_rst_stall", stall_cnt_o, 0);
    repeat (3) tick();
    chk("mid_rst_no_leak", out_q.size(), 0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n = $urandom_range(99) != 0;
      valid_i = $urandom_range(9) < 7;
      ready_i = $urandom_range(9) < 7;
      stall_i = $urandom_range(9) == 0;
      flush_i = $urandom_range(29) == 0;
      ctrl_i = CW'($urandom);
      data_i = {$urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
